// File: rtl/calc_pkg.sv
// Shared types for the calculator request/response protocol.
package calc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP    = 4'd0,
        CMD_ADD    = 4'd1,
        CMD_SUB    = 4'd2,
        CMD_LSHIFT = 4'd5,
        CMD_RSHIFT = 4'd6
    } calc_cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE    = 2'd0,
        RESP_OK      = 2'd1,
        RESP_IN_ERR  = 2'd2,
        RESP_INT_ERR = 2'd3
    } calc_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GET_OP2 = 2'd1,
        ST_EXEC    = 2'd2,
        ST_RESP    = 2'd3
    } calc_state_e;

endpackage

// File: rtl/calc_alu_core.sv
// Combinational calculator datapath: add/sub with range checks, optional shifter.
// Shifter is built only when CALC_SHIFT_EN is defined; otherwise shifts are input errors.
module calc_alu_core
    import calc_pkg::*;
(
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output calc_resp_e        resp_c,
    output logic [DATA_W-1:0] data_c
);

`ifdef CALC_SHIFT_EN
    localparam int unsigned SHAMT_W = 5;
`endif

    logic [DATA_W:0] sum_c;

    // Result and response code; anything not explicitly handled is an input error.
    always_comb begin
        sum_c  = {1'b0, op1} + {1'b0, op2};
        resp_c = RESP_IN_ERR;
        data_c = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum_c[DATA_W]) begin
                    resp_c = RESP_OK;
                    data_c = sum_c[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    resp_c = RESP_OK;
                    data_c = op1 - op2;
                end
            end
`ifdef CALC_SHIFT_EN
            CMD_LSHIFT: begin
                resp_c = RESP_OK;
                data_c = op1 << op2[SHAMT_W-1:0];
            end
            CMD_RSHIFT: begin
                resp_c = RESP_OK;
                data_c = op1 >> op2[SHAMT_W-1:0];
            end
`endif
            default: begin
                resp_c = RESP_IN_ERR;
                data_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc_port_responder.sv
// Single-port calculator responder: cmd+op1, then op2, EXEC_LAT execute cycles,
// then a one-cycle registered response. Optional shifter via CALC_SHIFT_EN.
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int unsigned EXEC_LAT = 1
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic [RESP_W-1:0] out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    calc_state_e       state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RESP_W-1:0] resp_d;
    logic [DATA_W-1:0] data_d;
    logic              busy_d;

    calc_resp_e        alu_resp_c;
    logic [DATA_W-1:0] alu_data_c;

    calc_alu_core u_alu (
        .cmd    (cmd_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .resp_c (alu_resp_c),
        .data_c (alu_data_c)
    );

    // Next-state, operand capture and response generation.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        resp_d  = '0;
        data_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_cmd_in != '0) begin
                    cmd_d   = req_cmd_in;
                    op1_d   = req_data_in;
                    state_d = ST_GET_OP2;
                end
            end
            ST_GET_OP2: begin
                op2_d   = req_data_in;
                cnt_d   = CNT_W'(EXEC_LAT - 1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    resp_d  = alu_resp_c;
                    data_d  = alu_data_c;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            cnt_q    <= '0;
            out_resp <= '0;
            out_data <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            cnt_q    <= cnt_d;
            out_resp <= resp_d;
            out_data <= data_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_calc_port_responder.sv
// Bench for calc_port_responder: EXEC_LAT=1 and EXEC_LAT=4 instances on shared stimulus,
// checked every cycle against a transaction-level model, plus literal spot checks.
module tb_calc_port_responder;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  resp1, resp4;
    logic [31:0] data1, data4;
    logic        busy1, busy4;

    int tests = 0;
    int fails = 0;

    always #5 c_clk = ~c_clk;

    calc_port_responder #(.EXEC_LAT(1)) dut1 (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(resp1), .out_data(data1), .busy(busy1)
    );

    calc_port_responder #(.EXEC_LAT(4)) dut4 (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(resp4), .out_data(data4), .busy(busy4)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: returns {resp, data}.
    function automatic logic [33:0] ref_calc(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] s;
        s = {32'd0, a} + {32'd0, b};
        case (c)
            4'd1: return (s > 64'h0000_0000_FFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
`ifdef CALC_SHIFT_EN
            4'd5: return {2'd1, a << (b % 32)};
            4'd6: return {2'd1, a >> (b % 32)};
`endif
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // Transaction-level model: per instance, capture edge, response edge, next free edge.
    int unsigned lat [2] = '{1, 4};
    longint      edge_n = 0;
    longint      cap_e  [2] = '{0, 0};
    longint      resp_e [2] = '{0, 0};
    longint      free_e [2] = '{0, 0};
    logic        pend   [2] = '{1'b0, 1'b0};
    logic [3:0]  m_cmd  [2];
    logic [31:0] m_op1  [2];
    logic [31:0] m_op2  [2];

    always @(posedge c_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                pend[i]   = 1'b0;
                free_e[i] = edge_n + 1;
            end else begin
                if (pend[i] && edge_n == cap_e[i] + 1) m_op2[i] = req_data_in;
                if (pend[i] && edge_n > resp_e[i]) pend[i] = 1'b0;
                if (edge_n >= free_e[i] && req_cmd_in != 4'd0) begin
                    pend[i]   = 1'b1;
                    cap_e[i]  = edge_n;
                    m_cmd[i]  = req_cmd_in;
                    m_op1[i]  = req_data_in;
                    resp_e[i] = edge_n + 1 + longint'(lat[i]);
                    free_e[i] = resp_e[i] + 2;
                end
            end
        end
        edge_n = edge_n + 1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(posedge c_clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            longint      k;
            logic [33:0] e;
            logic        eb;
            k  = edge_n - 1;
            e  = (pend[i] && k == resp_e[i]) ? ref_calc(m_cmd[i], m_op1[i], m_op2[i]) : 34'd0;
            eb = pend[i] && k >= cap_e[i] && k <= resp_e[i];
            check($sformatf("lat%0d resp @%0d", lat[i], k),
                  32'((i == 0) ? resp1 : resp4), 32'(e[33:32]));
            check($sformatf("lat%0d data @%0d", lat[i], k),
                  (i == 0) ? data1 : data4, e[31:0]);
            check($sformatf("lat%0d busy @%0d", lat[i], k),
                  32'((i == 0) ? busy1 : busy4), 32'(eb));
        end
    end

    int pc1 = 0;
    int pc4 = 0;
    always @(negedge c_clk) begin
        if (resp1 != 2'd0) pc1++;
        if (resp4 != 2'd0) pc4++;
    end

    // One transaction with a literal check of the EXEC_LAT=1 response; leaves both idle.
    task automatic txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] er, input logic [31:0] ed, input string nm);
        @(negedge c_clk); req_cmd_in = c;    req_data_in = a;
        @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = b;
        @(posedge c_clk); @(posedge c_clk); #2;
        check({nm, " resp"}, 32'(resp1), 32'(er));
        check({nm, " data"}, data1, ed);
        repeat (4) @(negedge c_clk);
    endtask

    function automatic logic [3:0] pick_cmd();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 3) return 4'd1;
        if (r < 6) return 4'd2;
        if (r == 6) return 4'd5;
        if (r == 7) return 4'd6;
        if (r == 8) return 4'd3;
        return 4'($urandom_range(7, 15));
    endfunction

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'd0;
            2: return 32'($urandom_range(0, 40));
            3: return 32'h8000_0000 | $urandom;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [33:0] r;
        int          p1, p4;
        logic [1:0]  sh_r;
        logic [31:0] sh_l, sh_rd;

        reset = 1'b1; req_cmd_in = 4'd0; req_data_in = 32'd0;
        repeat (3) @(negedge c_clk);
        check("reset resp1", 32'(resp1), 32'd0);
        check("reset data1", data1, 32'd0);
        check("reset busy1", 32'(busy1), 32'd0);
        check("reset resp4", 32'(resp4), 32'd0);
        check("reset busy4", 32'(busy4), 32'd0);
        reset = 1'b0;

        r = ref_calc(4'd1, 32'h8000_2345, 32'h0001_0000);
        check("model add", r[31:0], 32'h8001_2345);
        r = ref_calc(4'd2, 32'd5, 32'd6);
        check("model sub underflow", 32'(r[33:32]), 32'd2);

`ifdef CALC_SHIFT_EN
        sh_r = 2'd1; sh_l = 32'd2; sh_rd = 32'd1;
`else
        sh_r = 2'd2; sh_l = 32'd0; sh_rd = 32'd0;
`endif
        txn(4'd1, 32'h8000_2345, 32'h0001_0000, 2'd1, 32'h8001_2345, "add");
        txn(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0, "add carry");
        txn(4'd2, 32'd5, 32'd6, 2'd2, 32'd0, "sub underflow");
        txn(4'd2, 32'd6, 32'd5, 2'd1, 32'd1, "sub");
        txn(4'd5, 32'h0000_0001, 32'h0000_0021, sh_r, sh_l, "lshift");
        txn(4'd6, 32'h8000_0000, 32'd31, sh_r, sh_rd, "rshift");
        txn(4'd3, $urandom, $urandom, 2'd2, 32'd0, "cmd3");

        // EXEC_LAT=4: response registered 5 edges after capture, one cycle wide.
        @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd2;
        @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd3;
        repeat (4) @(posedge c_clk); #2;
        check("lat4 early resp", 32'(resp4), 32'd0);
        @(posedge c_clk); #2;
        check("lat4 resp", 32'(resp4), 32'd1);
        check("lat4 data", data4, 32'd5);
        @(posedge c_clk); #2;
        check("lat4 resp after pulse", 32'(resp4), 32'd0);

        // Second command presented during EXEC is dropped.
        p1 = pc1; p4 = pc4;
        @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd10;
        @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd20;
        @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd7;
        @(negedge c_clk); req_cmd_in = 4'd0;
        repeat (8) @(negedge c_clk);
        check("drop pulses lat1", 32'(pc1 - p1), 32'd1);
        check("drop pulses lat4", 32'(pc4 - p4), 32'd1);

        // Reset while the EXEC_LAT=4 instance is executing.
        p4 = pc4;
        @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd100;
        @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd200;
        @(negedge c_clk);
        @(negedge c_clk); reset = 1'b1;
        @(posedge c_clk); #2;
        check("mid reset resp4", 32'(resp4), 32'd0);
        check("mid reset busy4", 32'(busy4), 32'd0);
        check("mid reset busy1", 32'(busy1), 32'd0);
        @(negedge c_clk); reset = 1'b0;
        repeat (8) @(negedge c_clk);
        check("no resp after reset lat4", 32'(pc4 - p4), 32'd0);
        txn(4'd1, 32'd7, 32'd8, 2'd1, 32'd15, "add after reset");

        // Random traffic, including drops, held commands and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge c_clk);
            reset       = ($urandom_range(0, 299) == 0);
            req_cmd_in  = ($urandom_range(0, 2) == 0) ? pick_cmd() : 4'd0;
            req_data_in = pick_data();
        end

        @(negedge c_clk); reset = 1'b0; req_cmd_in = 4'd0;
        repeat (10) @(negedge c_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_port_responder.md
# calc_port_responder

Single-port responder for the calculator request/response protocol. It accepts a command with operand 1, takes operand 2 on the following cycle, computes the result, and returns a one-cycle response code with the result data. It serves as the per-port execution engine behind the four request ports of the calculator top level, and as a standalone reference responder for port-level benches.

## Interface

Parameters:
- EXEC_LAT, 1: number of execute cycles between capturing operand 2 and registering the result; legal range 1–15.

Ports:
- c_clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- req_cmd_in  in  4  command: 0 No_Op, 1 Add, 2 Sub, 5 Left_shift, 6 Right_shift
- req_data_in  in  32  operand 1 in the command cycle, operand 2 in the next cycle
- out_resp  out  2  0 No_response, 1 Successful, 2 Input_error, 3 Internal_error
- out_data  out  32  result; valid only while out_resp != 0
- busy  out  1  high from the cycle after command capture through the response cycle

## Operation

- FSM states are IDLE, GET_OP2, EXEC, and RESP.
- IDLE
  - If req_cmd_in != 0 at an edge, latch cmd and op1 and move to GET_OP2.
  - If req_cmd_in == 0, stay in IDLE.
- GET_OP2: latch req_data_in as op2 at the next edge, unconditionally. req_cmd_in is ignored. Load exec_cnt = EXEC_LAT-1 and move to EXEC.
- EXEC
  - While exec_cnt != 0, decrement it.
  - When exec_cnt == 0, register out_resp/out_data and move to RESP.
- RESP: hold the response for exactly one cycle, then return to IDLE.
- Commands presented outside IDLE are dropped, with no response and no queuing.
- Arithmetic is unsigned 32-bit:
  - Add: if op1+op2 carries out of bit 31, resp=2 and data=0. Otherwise resp=1 and data=sum.
  - Sub: if op2 > op1 (underflow), resp=2 and data=0. Otherwise resp=1 and data=op1-op2.
  - Left_shift: data = op1 << op2[4:0], resp=1. op2[31:5] is ignored. Bits shifted out are lost, with no error.
  - Right_shift: data = op1 >> op2[4:0] (logical), resp=1.
  - Any other nonzero cmd (3, 4, 7–15): resp=2, data=0.
- out_resp and out_data are 0 in every state except RESP.
- resp=3 is reserved. This block never generates it.

## Timing

- Reset values: state=IDLE, out_resp=0, out_data=0, busy=0, and all internal registers 0.
- Reset is sampled at each edge. Reset mid-transaction discards the transaction, and no response is ever produced for it.
- Latency with cmd captured at edge E0:
  - op2 is captured at E1.
  - The result is registered at E(1+EXEC_LAT).
  - out_resp/out_data are valid for one cycle after that edge.
- With EXEC_LAT=1, the response is visible between E2 and E3. The earliest next command is captured at E4.
- Drivers change inputs on the falling edge. Operand 2 must be stable at E1.
- The response pulse is exactly one cycle and has no back-pressure. A consumer that polls out_resp != 0 on falling edges sees it.
- A cmd held nonzero through GET_OP2..RESP is ignored. If it is still nonzero in IDLE, it is captured again as a new command.

## Configuration

- CALC_SHIFT_EN defined: Left_shift and Right_shift execute as described above.
- CALC_SHIFT_EN undefined: the shifter logic is not compiled. Commands 5 and 6 return resp=2, data=0 with the same latency as other commands.

## Structure

- Package calc_pkg holds the following. No per-port logic goes in the package.
  - The calc_cmd_e enum (4-bit).
  - The calc_resp_e enum (2-bit).
  - The state enum.
- One sub-module, calc_alu_core:
  - Combinational.
  - Takes cmd, op1, op2 and produces resp and data.
  - Holds the overflow/underflow checks and the shifter under CALC_SHIFT_EN.
- calc_port_responder owns the FSM, the operand registers, exec_cnt, and the output registers.

## Test plan

- Add 0x80002345 + 0x00010000: resp=1, data=0x80012345. With EXEC_LAT=1, the response is visible in the cycle after E2.
- Add 0xFFFFFFFF + 0x00000001: resp=2, data=0. Sub 5 - 6: resp=2, data=0. Sub 6 - 5: resp=1, data=1.
- Left_shift 0x00000001 by 0x00000021 (bits [4:0]=1): resp=1, data=0x00000002. Right_shift 0x80000000 by 31: data=0x00000001. Without CALC_SHIFT_EN, both return resp=2.
- cmd=3 with any operands: resp=2, data=0. A second Add presented during EXEC: dropped, and only one response pulse occurs.
- Reset asserted during EXEC: the next edge gives out_resp=0 and busy=0, no response ever appears, and a fresh Add after reset completes normally.
- EXEC_LAT=4, Add 2+3: response data=5 appears 5 edges after cmd capture and lasts exactly one cycle.
